// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared constants for the peripheral bus master.
// funct3 codes, FSM state encoding, timeout counter sizing helper.
package periph_bus_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RESP
    } state_t;

    // Counter only has to reach TIMEOUT_CYCLES-1 before expiry fires.
    function automatic int to_cnt_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/periph_lane_align.sv
// periph_lane_align: RV32I sub-word lane steering (store) and extract/extend (load).
// Ports: st_funct3/st_off/st_wdata -> st_data/st_mask ; ld_funct3/ld_off/ld_data -> ld_result.
module periph_lane_align
    import periph_bus_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_data,
    output logic [3:0]  st_mask,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_data,
    output logic [31:0] ld_result
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_data = st_wdata;
        st_mask = 4'b1111;
        case (st_funct3)
            F3_B: begin
                st_data = {4{st_wdata[7:0]}};
                st_mask = 4'b0001 << st_off;
            end
            F3_H: begin
                st_data = {2{st_wdata[15:0]}};
                st_mask = 4'b0011 << {st_off[1], 1'b0};
            end
            default: ;
        endcase
    end

    // Half select uses bit 1 only, so a misaligned half reads its containing half.
    always_comb begin
        ld_byte   = ld_data[{ld_off, 3'b000} +: 8];
        ld_half   = ld_data[{ld_off[1], 4'b0000} +: 16];
        ld_result = ld_data;
        case (ld_funct3)
            F3_B:    ld_result = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_result = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_result = {24'h0, ld_byte};
            F3_HU:   ld_result = {16'h0, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/periph_bus_master.sv
// periph_bus_master: single-outstanding CPU load/store initiator for the peripheral bus.
// Ports: req_* (CPU request), resp_* (1-cycle completion), add_w/data_w/wen/wmask<-wready
// (write channel), add_r/ren<-data_r/rvalid (read channel). TIMEOUT_CYCLES=0 disables timeout.
// Optional: define PERIPH_MISALIGN_TRAP_EN to error misaligned half/word accesses.
module periph_bus_master
    import periph_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] add_w,
    output logic [31:0]       data_w,
    output logic              wen,
    output logic [3:0]        wmask,
    input  logic              wready,
    output logic [ADDR_W-1:0] add_r,
    output logic              ren,
    input  logic [31:0]       data_r,
    input  logic              rvalid
);

    localparam int CNT_W = to_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic             accept, legal, misalign, req_ok, expired;
    logic [31:0]      st_data, ld_result;
    logic [3:0]       st_mask;

    assign accept = (state_q == ST_IDLE) && req_valid;
    assign legal  = req_we ? (req_funct3 inside {F3_B, F3_H, F3_W})
                           : (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

`ifdef PERIPH_MISALIGN_TRAP_EN
    assign misalign = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])
                   || ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_ok  = legal && !misalign;
    assign expired = TO_EN && (cnt_q == CNT_LAST);

    assign req_ready  = (state_q == ST_IDLE);
    assign wen        = (state_q == ST_WRITE);
    assign ren        = (state_q == ST_READ);
    assign resp_valid = (state_q == ST_RESP);

    periph_lane_align u_align (
        .st_funct3 (req_funct3),
        .st_off    (req_addr[1:0]),
        .st_wdata  (req_wdata),
        .st_data   (st_data),
        .st_mask   (st_mask),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .ld_data   (data_r),
        .ld_result (ld_result)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!req_ok)     state_d = ST_RESP;
                    else if (req_we) state_d = ST_WRITE;
                    else             state_d = ST_READ;
                end
            end
            ST_WRITE: if (wready || expired) state_d = ST_RESP;
            ST_READ:  if (rvalid || expired) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Completion in the expiry cycle wins, so err is only set when the
    // handshake is absent.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            add_w      <= '0;
            add_r      <= '0;
            data_w     <= '0;
            wmask      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cnt_q      <= '0;
                        f3_q       <= req_funct3;
                        off_q      <= req_addr[1:0];
                        resp_rdata <= '0;
                        resp_err   <= !req_ok;
                        if (req_ok && req_we) begin
                            add_w  <= {req_addr[ADDR_W-1:2], 2'b00};
                            data_w <= st_data;
                            wmask  <= st_mask;
                        end
                        if (req_ok && !req_we) begin
                            add_r <= {req_addr[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                ST_WRITE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!wready && expired) resp_err <= 1'b1;
                end
                ST_READ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (rvalid)       resp_rdata <= ld_result;
                    else if (expired) resp_err   <= 1'b1;
                end
                ST_RESP: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
